network_sequencer: RTL and testbench

NETWORK_SEQUENCER -- requirements
Module: network_sequencer

---
 rtl/network_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_network_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/network_sequencer.sv
// Drives one sample at a time into a network, waits for the rising edge of its ready flag, and
// emits a result record with a per-element tolerance check against the golden output.
module network_sequencer #(
  parameter int unsigned INPUT_SZ       = 2,
  parameter int unsigned OUTPUT_SZ      = 1,
  parameter int unsigned QN             = 6,
  parameter int unsigned QM             = 11,
  parameter int unsigned BITWIDTH       = QN + QM + 1,
  parameter int unsigned TOL            = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned MAX_SAMPLES    = 0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BITWIDTH*INPUT_SZ-1:0]  in_vec,
  input  logic [BITWIDTH*OUTPUT_SZ-1:0] in_golden,
  output logic [BITWIDTH*INPUT_SZ-1:0]  net_input,
  output logic                          net_newSample,
  input  logic                          net_dataReady,
  input  logic [BITWIDTH*OUTPUT_SZ-1:0] net_output,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BITWIDTH*OUTPUT_SZ-1:0] out_vec,
  output logic [OUTPUT_SZ-1:0]          out_mismatch,
  output logic                          out_timeout,
  output logic [15:0]                   sample_count,
  output logic [15:0]                   error_count,
  output logic                          done
);

  localparam int unsigned       TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]     TimerLast = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [BITWIDTH:0] TolW      = (BITWIDTH + 1)'(TOL);
  localparam logic [15:0]       MaxW      = 16'(MAX_SAMPLES);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StEmit, StDone} state_e;

  state_e                        state_q, state_d;
  logic                          in_ready_q, in_ready_d;
  logic                          newsample_q, newsample_d;
  logic [BITWIDTH*INPUT_SZ-1:0]  net_input_q, net_input_d;
  logic [BITWIDTH*OUTPUT_SZ-1:0] golden_q, golden_d;
  logic                          out_valid_q, out_valid_d;
  logic [BITWIDTH*OUTPUT_SZ-1:0] out_vec_q, out_vec_d;
  logic [OUTPUT_SZ-1:0]          mismatch_q, mismatch_d;
  logic                          timeout_q, timeout_d;
  logic [15:0]                   sample_count_q, sample_count_d;
  logic [15:0]                   error_count_q, error_count_d;
  logic                          done_q, done_d;
  logic                          ready_prev_q;
  logic [TW-1:0]                 timer_q, timer_d;

  logic                          ready_rise;
  logic [15:0]                   sample_inc, error_inc;
  logic [BITWIDTH:0]             diff [OUTPUT_SZ];
  logic [BITWIDTH:0]             mag  [OUTPUT_SZ];
  logic [OUTPUT_SZ-1:0]          mism;

  // Sign-extend by one bit so the difference of two extreme values cannot wrap.
  always_comb begin
    mism = '0;
    for (int i = 0; i < OUTPUT_SZ; i++) begin
      diff[i] = {net_output[i*BITWIDTH+BITWIDTH-1], net_output[i*BITWIDTH +: BITWIDTH]} -
                {golden_q[i*BITWIDTH+BITWIDTH-1], golden_q[i*BITWIDTH +: BITWIDTH]};
      mag[i]  = diff[i][BITWIDTH] ? -diff[i] : diff[i];
      mism[i] = mag[i] > TolW;
    end
  end

  assign ready_rise = net_dataReady & ~ready_prev_q;
  assign sample_inc = (sample_count_q == 16'hFFFF) ? sample_count_q : sample_count_q + 16'd1;
  assign error_inc  = (error_count_q == 16'hFFFF) ? error_count_q : error_count_q + 16'd1;

  always_comb begin
    state_d        = state_q;
    in_ready_d     = in_ready_q;
    newsample_d    = 1'b0;
    net_input_d    = net_input_q;
    golden_d       = golden_q;
    out_valid_d    = out_valid_q;
    out_vec_d      = out_vec_q;
    mismatch_d     = mismatch_q;
    timeout_d      = timeout_q;
    sample_count_d = sample_count_q;
    error_count_d  = error_count_q;
    done_d         = done_q;
    timer_d        = timer_q;
    unique case (state_q)
      StIdle: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          net_input_d = in_vec;
          golden_d    = in_golden;
          in_ready_d  = 1'b0;
          newsample_d = 1'b1;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        timer_d = '0;
        state_d = StWait;
      end
      StWait: begin
        if (ready_rise) begin
          out_vec_d   = net_output;
          mismatch_d  = mism;
          timeout_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = StEmit;
        end else if (timer_q == TimerLast) begin
          out_vec_d   = '0;
          mismatch_d  = '1;
          timeout_d   = 1'b1;
          out_valid_d = 1'b1;
          state_d     = StEmit;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StEmit: begin
        if (out_valid_q && out_ready) begin
          out_valid_d    = 1'b0;
          sample_count_d = sample_inc;
          if (|mismatch_q || timeout_q) error_count_d = error_inc;
          if (MAX_SAMPLES != 0 && sample_inc == MaxW) begin
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            in_ready_d = 1'b1;
            state_d    = StIdle;
          end
        end
      end
      StDone: begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= StIdle;
      in_ready_q     <= 1'b0;
      newsample_q    <= 1'b0;
      net_input_q    <= '0;
      golden_q       <= '0;
      out_valid_q    <= 1'b0;
      out_vec_q      <= '0;
      mismatch_q     <= '0;
      timeout_q      <= 1'b0;
      sample_count_q <= '0;
      error_count_q  <= '0;
      done_q         <= 1'b0;
      ready_prev_q   <= 1'b0;
      timer_q        <= '0;
    end else begin
      state_q        <= state_d;
      in_ready_q     <= in_ready_d;
      newsample_q    <= newsample_d;
      net_input_q    <= net_input_d;
      golden_q       <= golden_d;
      out_valid_q    <= out_valid_d;
      out_vec_q      <= out_vec_d;
      mismatch_q     <= mismatch_d;
      timeout_q      <= timeout_d;
      sample_count_q <= sample_count_d;
      error_count_q  <= error_count_d;
      done_q         <= done_d;
      ready_prev_q   <= net_dataReady;
      timer_q        <= timer_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign net_newSample = newsample_q;
  assign net_input     = net_input_q;
  assign out_valid     = out_valid_q;
  assign out_vec       = out_vec_q;
  assign out_mismatch  = mismatch_q;
  assign out_timeout   = timeout_q;
  assign sample_count  = sample_count_q;
  assign error_count   = error_count_q;
  assign done          = done_q;

endmodule

// File: tb/tb_network_sequencer.sv
// Directed bench for network_sequencer: one default instance and one with a short timeout and a
// three-sample limit, sharing stimulus; sel chooses which instance's outputs are checked.
module tb_network_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [35:0] in_vec = '0;
  logic [17:0] in_golden = '0;
  logic        net_dataReady = 1'b0;
  logic [17:0] net_output = '0;
  logic        out_ready = 1'b0;
  logic        sel = 1'b0;

  logic        ir_a, ns_a, ov_a, to_a, dn_a, ir_b, ns_b, ov_b, to_b, dn_b;
  logic [35:0] ni_a, ni_b;
  logic [17:0] ovec_a, ovec_b;
  logic [0:0]  mm_a, mm_b;
  logic [15:0] sc_a, ec_a, sc_b, ec_b;

  logic        ir, ns, ov, to, dn;
  logic [35:0] ni;
  logic [17:0] ovec;
  logic [0:0]  mm;
  logic [15:0] sc, ec;

  int n_checks = 0;
  int n_fails  = 0;
  int ns_pulses = 0;

  always #5 clock = ~clock;

  network_sequencer u_dut_a (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(ir_a), .in_vec(in_vec),
    .in_golden(in_golden), .net_input(ni_a), .net_newSample(ns_a),
    .net_dataReady(net_dataReady), .net_output(net_output), .out_valid(ov_a),
    .out_ready(out_ready), .out_vec(ovec_a), .out_mismatch(mm_a), .out_timeout(to_a),
    .sample_count(sc_a), .error_count(ec_a), .done(dn_a)
  );

  network_sequencer #(.TIMEOUT_CYCLES(8), .MAX_SAMPLES(3)) u_dut_b (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(ir_b), .in_vec(in_vec),
    .in_golden(in_golden), .net_input(ni_b), .net_newSample(ns_b),
    .net_dataReady(net_dataReady), .net_output(net_output), .out_valid(ov_b),
    .out_ready(out_ready), .out_vec(ovec_b), .out_mismatch(mm_b), .out_timeout(to_b),
    .sample_count(sc_b), .error_count(ec_b), .done(dn_b)
  );

  assign ir   = sel ? ir_b   : ir_a;
  assign ns   = sel ? ns_b   : ns_a;
  assign ov   = sel ? ov_b   : ov_a;
  assign to   = sel ? to_b   : to_a;
  assign dn   = sel ? dn_b   : dn_a;
  assign ni   = sel ? ni_b   : ni_a;
  assign ovec = sel ? ovec_b : ovec_a;
  assign mm   = sel ? mm_b   : mm_a;
  assign sc   = sel ? sc_b   : sc_a;
  assign ec   = sel ? ec_b   : ec_a;

  always @(negedge clock) if (ns === 1'b1) ns_pulses <= ns_pulses + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, "_ir"}, ir, 0);
    check({nm, "_ns"}, ns, 0);
    check({nm, "_ov"}, ov, 0);
    check({nm, "_to"}, to, 0);
    check({nm, "_done"}, dn, 0);
    check({nm, "_nin"}, ni, 0);
    check({nm, "_ovec"}, ovec, 0);
    check({nm, "_mm"}, mm, 0);
    check({nm, "_sc"}, sc, 0);
    check({nm, "_ec"}, ec, 0);
  endtask

  task automatic do_reset(input string nm);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; net_dataReady = 1'b0; net_output = '0;
    repeat (2) @(negedge clock);
    check_reset_vals(nm);
    reset = 1'b0;
    @(negedge clock);
    check({nm, "_ir_after"}, ir, 1);
  endtask

  // Holds in_valid until in_ready is seen; returns at the negedge after the accepting edge.
  task automatic accept(input logic [35:0] v, input logic [17:0] g, output bit ok);
    ok = 1'b0; in_vec = v; in_golden = g; in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (ir === 1'b1) begin
        @(negedge clock);
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (ov !== 1'b1 && lat < 40) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic pop(input string nm, input int exp_sc, input int exp_ec);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0; net_dataReady = 1'b0;
    check({nm, "_ov_clr"}, ov, 0);
    check({nm, "_sc"}, sc, exp_sc);
    check({nm, "_ec"}, ec, exp_ec);
  endtask

  // dly: negedges after the newSample cycle before the network raises dataReady (>= 1).
  task automatic run_sample(input string nm, input logic [35:0] v, input logic [17:0] g,
                            input int dly, input logic [17:0] r, input logic em,
                            input int exp_sc, input int exp_ec);
    bit ok;
    int lat;
    accept(v, g, ok);
    check({nm, "_acc"}, ok, 1);
    check({nm, "_ns"}, ns, 1);
    check({nm, "_nin"}, ni, v);
    @(negedge clock);
    check({nm, "_ns_once"}, ns, 0);
    repeat (dly - 1) @(negedge clock);
    net_output = r; net_dataReady = 1'b1;
    wait_valid(lat);
    check({nm, "_lat"}, lat, 1);
    check({nm, "_ovec"}, ovec, r);
    check({nm, "_mm"}, mm, em);
    check({nm, "_to"}, to, 0);
    pop(nm, exp_sc, exp_ec);
  endtask

  initial begin
    bit ok;
    int lat, p0;
    @(negedge clock);
    do_reset("rst_a");

    p0 = ns_pulses;
    run_sample("single", {18'd2048, 18'd1024}, 18'd512, 10, 18'd520, 1'b0, 1, 0);
    check("single_pulses", ns_pulses - p0, 1);

    run_sample("tol_p17", 36'd5, 18'd512, 1, 18'd529, 1'b1, 2, 1);
    run_sample("tol_m16", 36'd6, 18'd512, 2, 18'd496, 1'b0, 3, 1);
    run_sample("tol_p16", 36'd7, 18'd512, 1, 18'd528, 1'b0, 4, 1);
    run_sample("tol_m17", 36'd8, 18'd512, 3, 18'd495, 1'b1, 5, 2);
    run_sample("tol_neg", 36'd9, 18'h3FF9C, 1, 18'd100, 1'b1, 6, 3);
    run_sample("tol_wrap", 36'd10, 18'h1FFFF, 1, 18'h20000, 1'b1, 7, 4);

    // Reset in the middle of WAIT abandons the sample.
    accept(36'd11, 18'd300, ok);
    check("rstw_acc", ok, 1);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_reset_vals("rstw");
    reset = 1'b0;
    @(negedge clock);
    check("rstw_ir", ir, 1);
    run_sample("rstw_next", 36'd12, 18'd300, 4, 18'd310, 1'b0, 1, 0);

    // A level already high before WAIT must not complete the sample.
    net_output = 18'd777; net_dataReady = 1'b1;
    @(negedge clock);
    accept(36'd13, 18'd777, ok);
    check("stale_acc", ok, 1);
    repeat (5) @(negedge clock);
    check("stale_ignored", ov, 0);
    net_dataReady = 1'b0;
    @(negedge clock);
    net_output = 18'd780; net_dataReady = 1'b1;
    wait_valid(lat);
    check("stale_lat", lat, 1);
    check("stale_ovec", ovec, 18'd780);
    check("stale_mm", mm, 0);
    net_output = 18'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("hold_ov", ov, 1);
      check("hold_ovec", ovec, 18'd780);
    end
    check("hold_sc", sc, 1);
    pop("stale", 2, 0);
    @(negedge clock);
    check("stale_sc_once", sc, 2);

    // Short-timeout, three-sample instance.
    sel = 1'b1;
    @(negedge clock);
    do_reset("rst_b");
    accept(36'd21, 18'd50, ok);
    check("tmo_acc", ok, 1);
    wait_valid(lat);
    check("tmo_lat", lat, 9);
    check("tmo_flag", to, 1);
    check("tmo_mm", mm, 1);
    check("tmo_ovec", ovec, 0);
    pop("tmo", 1, 1);

    run_sample("tmo_edge", 36'd22, 18'd60, 8, 18'd60, 1'b0, 2, 1);
    check("max_done2", dn, 0);
    run_sample("max_s3", 36'd23, 18'd70, 1, 18'd71, 1'b0, 3, 1);
    check("max_done", dn, 1);
    check("max_ir", ir, 0);
    p0 = ns_pulses;
    accept(36'd24, 18'd80, ok);
    check("max_4th_rej", ok, 0);
    check("max_4th_ns", ns_pulses - p0, 0);
    check("max_4th_sc", sc, 3);
    check("max_4th_ov", ov, 0);
    check("max_done_hold", dn, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
